// File: rtl/loctag_pkg.sv
// Shared types and helpers for the loctag reflector path.
// State enum, mode encodings and LFSR step/slot functions.
package loctag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    WAIT_SLOT,
    REFLECT
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_ON   = 2'b01;
  localparam logic [1:0] MODE_SUB  = 2'b10;
  localparam logic [1:0] MODE_TEST = 2'b11;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] v
  );
    logic [15:0] fb;
    fb = v[0] ? LFSR_MASK : 16'h0000;
    return (v >> 1) ^ fb;
  endfunction

  // Slot picked from the value the LFSR is about to take.
  function automatic logic [2:0] slot_pick(
    input logic [15:0] v,
    input logic [1:0]  q
  );
    logic [15:0] n;
    logic [2:0]  m;
    n = lfsr_next(v);
    case (q)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return n[2:0] & m;
  endfunction

endpackage

// File: rtl/reflect_scheduler_if.sv
// Trigger/mode inputs and reflector status outputs
// of the reflect scheduler, grouped as one bundle.
interface reflect_scheduler_if;

  logic       trig;
  logic [1:0] mode;
  logic [1:0] mac_q;
  logic       ctrl;
  logic       busy;
  logic [2:0] slot_sel;
  logic       done;

  modport master (
    output trig,
    output mode,
    output mac_q,
    input  ctrl,
    input  busy,
    input  slot_sel,
    input  done
  );

  modport slave (
    input  trig,
    input  mode,
    input  mac_q,
    output ctrl,
    output busy,
    output slot_sel,
    output done
  );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, right shift, stepped on demand.
// A zero seed would lock up, so it is replaced by 1.
module lfsr16
  import loctag_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h7654
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);

  localparam logic [15:0] INIT =
    (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= INIT;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/reflect_scheduler.sv
// Sequences the loctag reflector switch after each trigger:
// delay, random slot wait, then one slot of reflection.
module reflect_scheduler
  import loctag_pkg::*;
#(
  parameter int          CLK_FREQ_MHZ     = 50,
  parameter int          TRIG_DELAY_IN_US = 2,
  parameter int          SLOT_LEN_US      = 20,
  parameter int          MOD_HALF_PERIOD  = 25,
  parameter logic [15:0] MAC_SEED         = 16'h7654
) (
  input  logic               clk,
  input  logic               reset,
  reflect_scheduler_if.slave bus
);

  localparam int D  = TRIG_DELAY_IN_US * CLK_FREQ_MHZ;
  localparam int S  = SLOT_LEN_US * CLK_FREQ_MHZ;
  localparam int H  = MOD_HALF_PERIOD;
  localparam int SW = $clog2(7 * S + 1);
  localparam int DW = $clog2(D + 1);
  localparam int CW = (SW > DW) ? SW : DW;
  localparam int MW = $clog2(H + 1);

  localparam logic [CW-1:0] D_END = CW'(D - 1);
  localparam logic [CW-1:0] S_END = CW'(S - 1);
  localparam logic [CW-1:0] S_LEN = CW'(S);
  localparam logic [MW-1:0] H_END = MW'(H - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] wait_end;
  logic [MW-1:0] mod_q;
  logic [MW-1:0] mod_d;
  logic [MW-1:0] mod_step;
  logic          ctrl_q;
  logic          ctrl_d;
  logic          ctrl_step;
  logic          busy_q;
  logic          done_q;
  logic [2:0]    slot_q;
  logic [2:0]    slot_d;
  logic [1:0]    mode_l_q;
  logic [1:0]    mode_l_d;
  logic          trig_q;
  logic          test_q;
  logic          rise;
  logic          hold;
  logic          advance;
  logic [15:0]   lfsr_value;

  lfsr16 #(
    .SEED (MAC_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (advance),
    .value   (lfsr_value)
  );

  assign rise = bus.trig & ~trig_q;
  assign hold = (bus.mode == MODE_OFF) ||
                (bus.mode == MODE_TEST);

  assign wait_end = CW'(slot_q) * S_LEN - CW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    mode_l_d = mode_l_q;
    advance  = 1'b0;
    if (hold) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            advance  = 1'b1;
            slot_d   = slot_pick(lfsr_value, bus.mac_q);
            mode_l_d = bus.mode;
            cnt_d    = '0;
            state_d  = DELAY;
          end
        end
        DELAY: begin
          if (cnt_q == D_END) begin
            cnt_d   = '0;
            state_d = (slot_q == 3'd0) ? REFLECT : WAIT_SLOT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_SLOT: begin
          if (cnt_q == wait_end) begin
            cnt_d   = '0;
            state_d = REFLECT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REFLECT: begin
          if (cnt_q == S_END) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Subcarrier: each phase lasts H cycles, starting high.
  assign ctrl_step = (mod_q == H_END) ? ~ctrl_q : ctrl_q;
  assign mod_step  = (mod_q == H_END) ? '0 : mod_q + 1'b1;

  always_comb begin
    ctrl_d = 1'b0;
    mod_d  = '0;
    if (bus.mode == MODE_TEST) begin
      if (test_q) begin
        ctrl_d = ctrl_step;
        mod_d  = mod_step;
      end else begin
        ctrl_d = 1'b1;
      end
    end else if (state_d == REFLECT) begin
      if (state_q != REFLECT) begin
        ctrl_d = 1'b1;
      end else if (mode_l_q == MODE_SUB) begin
        ctrl_d = ctrl_step;
        mod_d  = mod_step;
      end else begin
        ctrl_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      slot_q   <= '0;
      mode_l_q <= MODE_OFF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      mode_l_q <= mode_l_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= 1'b0;
      mod_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      trig_q <= 1'b0;
      test_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      mod_q  <= mod_d;
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == REFLECT) &&
                (cnt_d == S_END);
      trig_q <= bus.trig;
      test_q <= (bus.mode == MODE_TEST);
    end
  end

  assign bus.ctrl     = ctrl_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.slot_sel = slot_q;

endmodule
